// File: rtl/fetch_unit.sv
// fetch_unit
// Instruction fetch front end. Owns the program counter, drives byte
// addresses to a memory with a one-cycle registered read, and captures the
// returned words into a small FIFO for the decoder. A credit check
// (queued + in-flight - leaving < DEPTH) gates every issue, so a returning
// word always has a free slot and nothing is dropped under back-pressure.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   imem_addr       byte address to instruction memory (registered PC)
//   imem_instr      read data, valid one cycle after its address
//   redirect_valid  load redirect_pc and flush everything in flight
//   redirect_pc     redirect target
//   out_valid       FIFO head valid
//   out_ready       decoder accepts the head
//   out_instr       head instruction word (0 when out_valid is low)
//   out_pc          byte address of the head (0 when out_valid is low)
//   out_fault       head was fetched from an illegal address
//   halted          fetch stopped after issuing an illegal address;
//                   this is also the run-state debug view
//
// Handshake: a head entry moves to the decoder on a rising edge where
// out_valid and out_ready are both high; out_valid never depends on
// out_ready, and a redirect in the same cycle cancels that transfer.
module fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          IMEM_BYTES = 1024,
   parameter int          DEPTH      = 4
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_instr,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [31:0] out_pc,
   output logic        out_fault,
   output logic        halted
);

   localparam int          PW      = $clog2(DEPTH);
   localparam int          CW      = $clog2(DEPTH + 1);
   localparam logic [31:0] LAST_OK = 32'(IMEM_BYTES - 4);
   localparam logic [31:0] NOP     = 32'h0000_0013;
   localparam logic [CW:0] LIMIT   = (CW + 1)'(DEPTH);

   localparam logic [0:0] ST_RUN  = 1'b0;
   localparam logic [0:0] ST_HALT = 1'b1;

   logic [31:0]   r_pc;
   logic          r_fly_v;
   logic [31:0]   r_fly_pc;
   logic          r_fly_fault;
   logic [0:0]    r_state;
   logic [CW-1:0] r_count;
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;

   logic [31:0] r_mem_instr [DEPTH];
   logic [31:0] r_mem_pc    [DEPTH];
   logic        r_mem_fault [DEPTH];

   logic        w_out_valid;
   logic        w_deq;
   logic        w_pc_bad;
   logic [CW:0] w_credit;
   logic [CW:0] w_limit;
   logic        w_issue;

   function automatic logic bad_addr(input logic [31:0] a);
      return (a[1:0] != 2'b00) || (a > LAST_OK);
   endfunction

   assign w_out_valid = (r_count != '0);
   assign w_deq       = w_out_valid & out_ready;
   assign w_pc_bad    = bad_addr(r_pc);

   // count + fly_v - deq < DEPTH, rearranged to avoid an unsigned underflow.
   assign w_credit = {1'b0, r_count} + {{CW{1'b0}}, r_fly_v};
   assign w_limit  = LIMIT + {{CW{1'b0}}, w_deq};
   assign w_issue  = (r_state == ST_RUN) & ~redirect_valid & (w_credit < w_limit);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pc        <= RESET_PC;
         r_fly_v     <= 1'b0;
         r_fly_pc    <= '0;
         r_fly_fault <= 1'b0;
         r_state     <= ST_RUN;
         r_count     <= '0;
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
      end else if (redirect_valid) begin
         // Redirect wins over issue, write and dequeue this cycle.
         r_pc     <= redirect_pc;
         r_state  <= ST_RUN;
         r_fly_v  <= 1'b0;
         r_count  <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_issue) begin
            r_fly_v     <= 1'b1;
            r_fly_pc    <= r_pc;
            r_fly_fault <= w_pc_bad;
            r_pc        <= r_pc + 32'd4;
            if (w_pc_bad) begin
               r_state <= ST_HALT;
            end
         end else begin
            r_fly_v <= 1'b0;
         end
         if (r_fly_v) begin
            r_wr_ptr <= r_wr_ptr + PW'(1);
         end
         if (w_deq) begin
            r_rd_ptr <= r_rd_ptr + PW'(1);
         end
         case ({r_fly_v, w_deq})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage needs no reset: every read is qualified by r_count.
   always_ff @(posedge clk) begin
      if (!rst && !redirect_valid && r_fly_v) begin
         r_mem_instr[r_wr_ptr] <= r_fly_fault ? NOP : imem_instr;
         r_mem_pc[r_wr_ptr]    <= r_fly_pc;
         r_mem_fault[r_wr_ptr] <= r_fly_fault;
      end
   end

   assign imem_addr = r_pc;
   assign out_valid = w_out_valid;
   assign out_instr = w_out_valid ? r_mem_instr[r_rd_ptr] : 32'h0;
   assign out_pc    = w_out_valid ? r_mem_pc[r_rd_ptr]    : 32'h0;
   assign out_fault = w_out_valid ? r_mem_fault[r_rd_ptr] : 1'b0;
   assign halted    = (r_state == ST_HALT);

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam int          IMEM_BYTES = 1024;

   logic        clk;
   logic        rst;
   logic [31:0] imem_addr;
   logic [31:0] imem_instr;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic        out_fault;
   logic        halted;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] mem [256];

   fetch_unit #(.RESET_PC(RESET_PC), .IMEM_BYTES(IMEM_BYTES), .DEPTH(4)) dut (
      .clk           (clk),
      .rst           (rst),
      .imem_addr     (imem_addr),
      .imem_instr    (imem_instr),
      .redirect_valid(redirect_valid),
      .redirect_pc   (redirect_pc),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_instr     (out_instr),
      .out_pc        (out_pc),
      .out_fault     (out_fault),
      .halted        (halted)
   );

   // ---------------- clock / memory ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      for (int i = 0; i < 256; i++) begin
         mem[i] = 32'h1357_0000 + i * 32'h0000_0101;
      end
   end

   // Instruction memory with a one-cycle registered read.
   initial imem_instr = 32'h0;
   always @(posedge clk) imem_instr <= mem[imem_addr[9:2]];

   // ---------------- checking helpers ----------------
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic is_bad(input logic [31:0] a);
      return (a % 4 != 0) || (a + 4 > IMEM_BYTES);
   endfunction

   // ---------------- behavioural model + compare ----------------
   // The model is the program-order stream: the next entry handed to the
   // decoder must be the next sequential address since the last reset or
   // redirect, nothing may follow a faulting entry, and idle outputs are 0.
   logic [31:0] exp_next = RESET_PC;
   logic        exp_done = 1'b0;

   always @(negedge clk) begin
      if (rst) begin
         exp_next = RESET_PC;
         exp_done = 1'b0;
         chk("rst_idle", {63'h0, out_valid}, 64'h0);
      end else begin
         if (out_valid) begin
            chk("after_fault", {63'h0, exp_done}, 64'h0);
            chk("head_pc", {32'h0, out_pc}, {32'h0, exp_next});
            chk("head_fault", {63'h0, out_fault}, {63'h0, is_bad(exp_next)});
            chk("head_instr", {32'h0, out_instr},
                {32'h0, is_bad(exp_next) ? 32'h0000_0013 : mem[exp_next[9:2]]});
         end else begin
            chk("idle_zero", {31'h0, out_fault, out_pc}, 64'h0);
            chk("idle_instr", {32'h0, out_instr}, 64'h0);
         end
         if (redirect_valid) begin
            exp_next = redirect_pc;
            exp_done = 1'b0;
         end else if (out_valid && out_ready) begin
            if (is_bad(exp_next)) exp_done = 1'b1;
            exp_next = exp_next + 32'd4;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic do_redirect(input logic [31:0] target);
      @(posedge clk); #1;
      redirect_valid = 1'b1;
      redirect_pc    = target;
      @(posedge clk); #1;
      redirect_valid = 1'b0;
   endtask

   task automatic release_reset();
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      logic [31:0] drain_pc [6];
      bit found;
      drain_pc = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14};

      rst = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc = 32'h0;
      out_ready = 1'b1;
      repeat (2) @(negedge clk);

      // Reset values
      chk("reset_valid", {63'h0, out_valid}, 64'h0);
      chk("reset_instr", {32'h0, out_instr}, 64'h0);
      chk("reset_pc", {32'h0, out_pc}, 64'h0);
      chk("reset_fault", {63'h0, out_fault}, 64'h0);
      chk("reset_halted", {63'h0, halted}, 64'h0);
      chk("reset_addr", {32'h0, imem_addr}, {32'h0, RESET_PC});

      // Streaming after reset release
      release_reset();
      @(negedge clk);
      chk("lat_c1_valid", {63'h0, out_valid}, 64'h0);
      chk("lat_c1_addr", {32'h0, imem_addr}, 64'h0);
      @(negedge clk);
      chk("lat_c2_valid", {63'h0, out_valid}, 64'h0);
      chk("lat_c2_addr", {32'h0, imem_addr}, 64'h4);
      @(negedge clk);
      chk("first_valid", {63'h0, out_valid}, 64'h1);
      chk("first_pc", {32'h0, out_pc}, 64'h0);
      chk("first_instr", {32'h0, out_instr}, 64'h1357_0000);
      @(negedge clk);
      chk("second_pc", {32'h0, out_pc}, 64'h4);
      chk("second_instr", {32'h0, out_instr}, 64'h1357_0101);
      repeat (4) @(negedge clk);

      // Back-pressure from reset: queue fills, PC stops at 0x10
      @(posedge clk); #1;
      rst = 1'b1;
      out_ready = 1'b0;
      release_reset();
      repeat (12) @(negedge clk);
      chk("bp_addr", {32'h0, imem_addr}, 64'h10);
      chk("bp_valid", {63'h0, out_valid}, 64'h1);
      chk("bp_head", {32'h0, out_pc}, 64'h0);
      @(posedge clk); #1;
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("drain_valid", {63'h0, out_valid}, 64'h1);
         chk("drain_pc", {32'h0, out_pc}, {32'h0, drain_pc[i]});
      end

      // Redirect to 0x40 while a dequeue happens with entries queued
      @(posedge clk); #1;
      redirect_valid = 1'b1;
      redirect_pc = 32'h40;
      @(negedge clk);
      chk("rd_deq_valid", {63'h0, out_valid}, 64'h1);
      @(posedge clk); #1;
      redirect_valid = 1'b0;
      @(negedge clk);
      chk("rd_r1_addr", {32'h0, imem_addr}, 64'h40);
      chk("rd_r1_valid", {63'h0, out_valid}, 64'h0);
      @(negedge clk);
      chk("rd_r2_valid", {63'h0, out_valid}, 64'h0);
      @(negedge clk);
      chk("rd_r3_valid", {63'h0, out_valid}, 64'h1);
      chk("rd_r3_pc", {32'h0, out_pc}, 64'h40);
      chk("rd_r3_instr", {32'h0, out_instr}, 64'h1357_1010);

      // Run off the end of memory
      do_redirect(32'h3F0);
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clk);
         if (out_valid && out_pc == 32'h3FC) found = 1'b1;
      end
      chk("end_seen_3fc", {63'h0, found}, 64'h1);
      chk("end_3fc_fault", {63'h0, out_fault}, 64'h0);
      chk("end_3fc_instr", {32'h0, out_instr}, 64'h1357_FFFF);
      @(negedge clk);
      chk("end_400_pc", {32'h0, out_pc}, 64'h400);
      chk("end_400_fault", {63'h0, out_fault}, 64'h1);
      chk("end_400_instr", {32'h0, out_instr}, 64'h13);
      chk("end_halted", {63'h0, halted}, 64'h1);
      repeat (3) @(negedge clk);
      chk("halt_idle", {63'h0, out_valid}, 64'h0);
      chk("halt_addr", {32'h0, imem_addr}, 64'h404);
      chk("halt_stays", {63'h0, halted}, 64'h1);

      do_redirect(32'h0);
      @(negedge clk);
      chk("resume_halted", {63'h0, halted}, 64'h0);
      chk("resume_addr", {32'h0, imem_addr}, 64'h0);
      repeat (2) @(negedge clk);
      chk("resume_pc", {32'h0, out_pc}, 64'h0);
      chk("resume_valid", {63'h0, out_valid}, 64'h1);

      // Misaligned redirect faults when issued
      do_redirect(32'h42);
      @(negedge clk);
      chk("mis_r1_halted", {63'h0, halted}, 64'h0);
      chk("mis_r1_addr", {32'h0, imem_addr}, 64'h42);
      @(negedge clk);
      chk("mis_r2_halted", {63'h0, halted}, 64'h1);
      @(negedge clk);
      chk("mis_valid", {63'h0, out_valid}, 64'h1);
      chk("mis_pc", {32'h0, out_pc}, 64'h42);
      chk("mis_fault", {63'h0, out_fault}, 64'h1);
      chk("mis_instr", {32'h0, out_instr}, 64'h13);

      // Asynchronous reset with a filling queue and a fetch in flight
      do_redirect(32'h0);
      repeat (3) @(negedge clk);
      @(posedge clk); #1;
      out_ready = 1'b0;
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      chk("arst_valid", {63'h0, out_valid}, 64'h0);
      chk("arst_outs", {31'h0, out_fault, out_pc}, 64'h0);
      chk("arst_instr", {32'h0, out_instr}, 64'h0);
      chk("arst_halted", {63'h0, halted}, 64'h0);
      chk("arst_addr", {32'h0, imem_addr}, {32'h0, RESET_PC});
      out_ready = 1'b1;
      release_reset();
      repeat (2) @(negedge clk);
      chk("restart_gap", {63'h0, out_valid}, 64'h0);
      @(negedge clk);
      chk("restart_valid", {63'h0, out_valid}, 64'h1);
      chk("restart_pc", {32'h0, out_pc}, {32'h0, RESET_PC});
      repeat (4) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time %0t limit 200000", $time);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch front end: owns the program counter, issues byte addresses to `instruction_mem`, and captures the instruction words it returns into a small queue for the decoder. It accounts for the memory's one-cycle registered read latency with a credit scheme, so no fetched word is ever dropped under decode back-pressure. It also handles branch/jump redirects and halts on an illegal fetch address.

## Interface
- `RESET_PC`, 32'h0000_0000, PC loaded on reset
- `IMEM_BYTES`, 1024, instruction memory size in bytes; valid fetch addresses are 0..IMEM_BYTES-4
- `DEPTH`, 4, fetch queue entries; power of two, ≥2
- `clk`  in  1  single clock, all state on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `imem_addr`  out  32  byte address to instruction memory; equals `pc_q`, registered source
- `imem_instr`  in  32  memory read data; valid one cycle after the address was presented
- `redirect_valid`  in  1  load new PC, flush everything in flight
- `redirect_pc`  in  32  redirect target
- `out_valid`  out  1  queue head valid
- `out_ready`  in  1  decoder accepts head
- `out_instr`  out  32  head instruction word
- `out_pc`  out  32  byte address of head instruction
- `out_fault`  out  1  head entry is an illegal-address fetch
- `halted`  out  1  fetch stopped after a fault

## Operation
- State: `pc_q`, in-flight flag `fly_v` with `fly_pc` and `fly_fault`, DEPTH-entry FIFO {instr, pc, fault}, `count`, run state RUN/HALT.
- `deq` = `out_valid & out_ready`.
- Issue condition: state RUN, no redirect, and `count + fly_v - deq < DEPTH`.
- On issue: `fly_v<=1`, `fly_pc<=pc_q`, `fly_fault<=bad(pc_q)`, `pc_q<=pc_q+4`. The add is 32-bit modulo 2^32.
- `bad(a)` = `a[1:0]!=0` or `a > IMEM_BYTES-4`.
- No issue: `fly_v<=0`, `pc_q` holds.
- When `fly_v`, write a FIFO entry {fault ? 32'h0000_0013 : imem_instr, fly_pc, fly_fault}.
- A write into a full FIFO cannot occur; the credit rule guarantees this. Simultaneous write and dequeue leave `count` unchanged.
- Issuing a bad PC moves RUN→HALT. In HALT there is no issue. Entries already queued still drain in order.
- Redirect has priority over issue, write and dequeue in the same cycle:
  - FIFO cleared, `count<=0`, `fly_v<=0`
  - `pc_q<=redirect_pc`, state RUN
- A misaligned or out-of-range `redirect_pc` is faulted when it is issued, not at redirect time.
- When `out_valid=0`: `out_instr`, `out_pc` and `out_fault` drive 0.
- `halted` = (state==HALT).

## Timing
- Reset values:
  - `pc_q`=`imem_addr`=RESET_PC
  - `fly_v`=0, `count`=0, state RUN
  - `out_valid`=0, `out_instr`=0, `out_pc`=0, `out_fault`=0, `halted`=0
- First issue is in the first cycle after reset deasserts.
- Fetch-to-output latency: address issued in cycle N, data on `imem_instr` in N+1, written at end of N+1, `out_valid` in N+2.
- Throughput: one instruction per cycle with continuous `out_ready` for any DEPTH≥2.
- Redirect latency: redirect asserted in cycle R; `imem_addr`=target in R+1; target on `out_valid` in R+3.
- `out_*` come from FIFO registers only. There is no combinational path from `imem_instr` or `redirect_*` to outputs.
- `out_ready` affects only the next-state issue decision. It never reaches `imem_addr` combinationally.
- Reset asserted mid-operation clears all state immediately (asynchronous), regardless of queue contents.

## Test plan
- Reset release, memory words 0..7 loaded, `out_ready`=1:
  - `out_valid` first rises 2 cycles after release
  - `out_pc`=0,4,8,... on consecutive cycles, `out_instr` matching memory
- `out_ready`=0 for 10 cycles, then 1:
  - `count` saturates at 4, `imem_addr` stops at 0x10 (RESET_PC 0)
  - release drains pc 0,4,8,0xC, then continues at 0x10 with no gap and no duplicate
- Redirect to 0x40 in the same cycle as a dequeue with 3 entries queued:
  - queue flushed, no old PC appears afterwards
  - `imem_addr`=0x40 next cycle, `out_pc`=0x40 three cycles after redirect
- Run to pc 0x3FC with IMEM_BYTES=1024:
  - entry 0x3FC normal
  - entry 0x400 has `out_fault`=1, `out_instr`=0x00000013
  - `halted`=1, no further issue
  - redirect to 0x0 resumes
- Redirect to 0x42: entry pc 0x42 has `out_fault`=1 and `halted` rises.
- `rst` pulsed while the queue is full and an item is in flight:
  - all outputs return to reset values in the same cycle
  - fetch restarts at RESET_PC
